// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and the digit-to-pattern encoder.
// Latency: none (constants and a pure function).
// Backpressure: not applicable.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam logic [3:0] AN_OFF     = 4'hF;
  localparam int         NUM_DIGITS = 4;
  localparam int         IDX_W      = 2;

  // Active-low pattern, bit0 = segment a .. bit6 = segment g; non-decimal codes stay dark.
  function automatic logic [6:0] seg7_encode(input logic [3:0] value);
    logic [6:0] pat;
    pat = SEG_OFF;
    case (value)
      4'd0: pat = 7'b1000000;
      4'd1: pat = 7'b1111001;
      4'd2: pat = 7'b0100100;
      4'd3: pat = 7'b0110000;
      4'd4: pat = 7'b0011001;
      4'd5: pat = 7'b0010010;
      4'd6: pat = 7'b0000010;
      4'd7: pat = 7'b1111000;
      4'd8: pat = 7'b0000000;
      4'd9: pat = 7'b0010000;
      default: pat = SEG_OFF;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Slot timer for the digit scan: cycle counter within a slot plus digit index.
// Latency: flags are combinational from the counter registers.
// Backpressure: none; free-running once out of reset.
module seg7_scan_timer
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2500
) (
  input  logic             clk,
  input  logic             rst,
  output logic [IDX_W-1:0] idx,
  output logic             blank,
  output logic             slot_wrap,
  output logic             frame_wrap
);

  localparam int                CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]  BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt;

  assign slot_wrap  = (cnt == CNT_LAST);
  assign frame_wrap = slot_wrap && (idx == IDX_LAST);
  // The first BLANK_CYCLES of every slot keep all anodes off.
  assign blank      = (cnt < BLANK_END);

  // Cycle counter within the current digit slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (slot_wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Digit index advances at each slot boundary, 3 wraps back to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (slot_wrap) begin
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexes four active-low digits plus dots onto one shared segment bus.
// Latency: outputs registered one cycle after the slot counter; inputs sampled once per frame.
// Backpressure: none; inputs are snapshotted at frame start and later changes wait for the next frame.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] d3,
  input  logic [6:0] d2,
  input  logic [6:0] d1,
  input  logic [6:0] d0,
  input  logic [3:0] dots_in,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic [3:0] an,
  output logic       frame_start
);

  logic [IDX_W-1:0]      idx;
  logic                  blank;
  logic                  slot_wrap;
  logic                  frame_wrap;
  logic                  snap_arm;
  logic [6:0]            snap_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] snap_dots;

  seg7_scan_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .idx       (idx),
    .blank     (blank),
    .slot_wrap (slot_wrap),
    .frame_wrap(frame_wrap)
  );

  // snap_arm is high exactly while cnt==0 and idx==0: set by reset, then re-armed at each frame wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_arm <= 1'b1;
    end else begin
      snap_arm <= slot_wrap && frame_wrap;
    end
  end

  // Capture all digits and dots together at the head of each frame so no digit tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        snap_d[k] <= SEG_OFF;
      end
      snap_dots <= '1;
    end else if (snap_arm) begin
      snap_d[0] <= d0;
      snap_d[1] <= d1;
      snap_d[2] <= d2;
      snap_d[3] <= d3;
      snap_dots <= dots_in;
    end
  end

  // Announce the snapshot for the cycle that follows it.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= snap_arm;
    end
  end

  // Drive the selected digit, or all-off during the blanking gap at the start of each slot.
  always_ff @(posedge clk) begin
    if (rst || blank) begin
      an      <= AN_OFF;
      seg_out <= SEG_OFF;
      dp_out  <= 1'b1;
    end else begin
      an      <= ~(4'b0001 << idx);
      seg_out <= snap_d[idx];
      dp_out  <= snap_dots[idx];
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a short refresh period.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_seg7_scan_driver;
  import seg7_pkg::*;

  localparam int RD = 8;
  localparam int BC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] d3, d2, d1, d0;
  logic [3:0] dots_in;
  logic [6:0] seg_out;
  logic       dp_out;
  logic [3:0] an;
  logic       frame_start;

  int vectors     = 0;
  int miscompares = 0;
  int n           = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .d3         (d3),
    .d2         (d2),
    .d1         (d1),
    .d0         (d0),
    .dots_in    (dots_in),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .an         (an),
    .frame_start(frame_start)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic run_to(input int target);
    while (n < target) tick();
  endtask

  task automatic expect_out(input string tag, input logic [3:0] a, input logic [6:0] s, input logic p);
    check({tag, ".an"},  32'(an),      32'(a));
    check({tag, ".seg"}, 32'(seg_out), 32'(s));
    check({tag, ".dp"},  32'(dp_out),  32'(p));
  endtask

  int blank_cnt, c0, c1, c2, c3, other;
  logic [3:0] prev_an;
  int last_fs, fs_count;
  bit have_snap;
  logic [6:0] es [4];
  logic [3:0] edots;
  logic [3:0] sel;

  initial begin
    rst     = 1'b1;
    d3      = seg7_encode(4'd1);
    d2      = seg7_encode(4'd2);
    d1      = seg7_encode(4'd3);
    d0      = seg7_encode(4'd4);
    dots_in = 4'b1011;
    tick();
    tick();
    expect_out("rst", 4'hF, 7'h7F, 1'b1);
    check("rst.fs", 32'(frame_start), 32'd0);

    // Scenario 1: release reset; the next edge is E0.
    rst = 1'b0;
    n   = -1;
    tick();
    check("s1.fs_e0", 32'(frame_start), 32'd1);
    check("s1.an_e0", 32'(an), 32'hF);
    tick();
    check("s1.fs_e1", 32'(frame_start), 32'd0);
    check("s1.an_e1", 32'(an), 32'hF);
    tick();
    expect_out("s1.d0_first", 4'b1110, 7'b0011001, 1'b1);
    run_to(7);
    expect_out("s1.d0_last", 4'b1110, 7'b0011001, 1'b1);
    tick();
    check("s1.slot1_blank", 32'(an), 32'hF);
    run_to(10);
    expect_out("s1.d1_first", 4'b1101, 7'b0110000, 1'b1);
    run_to(18);
    expect_out("s2.d2", 4'b1011, 7'b0100100, 1'b0);
    run_to(26);
    expect_out("s2.d3", 4'b0111, 7'b1111001, 1'b1);

    // Scenario 2/3: tally frame 1; change inputs during digit 2.
    run_to(31);
    blank_cnt = 0; c0 = 0; c1 = 0; c2 = 0; c3 = 0; other = 0;
    while (n < 63) begin
      tick();
      case (an)
        4'hF:    blank_cnt++;
        4'hE:    c0++;
        4'hD:    c1++;
        4'hB:    c2++;
        4'h7:    c3++;
        default: other++;
      endcase
      if (n == 32) check("s2.fs_frame1", 32'(frame_start), 32'd1);
      if (n == 52) begin
        d0 = seg7_encode(4'd9);
        d3 = seg7_encode(4'd7);
      end
      if (n == 58) expect_out("s3.d3_old", 4'b0111, 7'b1111001, 1'b1);
    end
    check("s2.blank_cnt", 32'(blank_cnt), 32'd8);
    check("s2.an0_cnt", 32'(c0), 32'd6);
    check("s2.an1_cnt", 32'(c1), 32'd6);
    check("s2.an2_cnt", 32'(c2), 32'd6);
    check("s2.an3_cnt", 32'(c3), 32'd6);
    check("s2.bad_an", 32'(other), 32'd0);
    tick();
    check("s3.fs_frame2", 32'(frame_start), 32'd1);
    run_to(66);
    expect_out("s3.d0_new", 4'b1110, 7'b0010000, 1'b1);
    run_to(90);
    expect_out("s3.d3_new", 4'b0111, 7'b1111000, 1'b1);

    // Scenario 4: reset while digit 2 is lit.
    run_to(115);
    check("s4.pre_an", 32'(an), 32'hB);
    rst = 1'b1;
    tick();
    expect_out("s4.rst", 4'hF, 7'h7F, 1'b1);
    check("s4.rst_fs", 32'(frame_start), 32'd0);
    rst = 1'b0;
    n   = -1;
    tick();
    check("s4.fs_e0", 32'(frame_start), 32'd1);
    check("s4.an_e0", 32'(an), 32'hF);
    tick();
    check("s4.fs_e1", 32'(frame_start), 32'd0);
    check("s4.an_e1", 32'(an), 32'hF);
    tick();
    expect_out("s4.d0_first", 4'b1110, 7'b0010000, 1'b1);
    run_to(10);
    expect_out("s4.d1_first", 4'b1101, 7'b0110000, 1'b1);

    // Scenario 5: random inputs, invariant checks plus a snapshot model.
    prev_an   = an;
    last_fs   = 0;
    fs_count  = 0;
    have_snap = 1'b0;
    edots     = 4'hF;
    for (int k = 0; k < 4; k++) es[k] = 7'h7F;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (frame_start) begin
        es[0] = d0; es[1] = d1; es[2] = d2; es[3] = d3;
        edots = dots_in;
        check("r.fs_period", 32'(n - last_fs), 32'd32);
        last_fs   = n;
        have_snap = 1'b1;
        fs_count++;
      end
      check("r.onehot", 32'($countones(~an) <= 1), 32'd1);
      if (an != prev_an && prev_an != 4'hF) check("r.via_blank", 32'(an), 32'hF);
      if (an == 4'hF) begin
        check("r.blank_seg", 32'(seg_out), 32'h7F);
        check("r.blank_dp", 32'(dp_out), 32'd1);
      end else if (have_snap) begin
        for (int k = 0; k < 4; k++) begin
          sel = ~(4'b0001 << k);
          if (an == sel) begin
            check("r.seg", 32'(seg_out), 32'(es[k]));
            check("r.dp", 32'(dp_out), 32'(edots[k]));
          end
        end
      end
      prev_an = an;
      d0      = 7'($urandom);
      d1      = 7'($urandom);
      d2      = 7'($urandom);
      d3      = 7'($urandom);
      dots_in = 4'($urandom);
    end
    check("r.fs_count", 32'(fs_count >= 30), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
